// File: rtl/avalon_sample_loader.sv
// avalon_sample_loader: Avalon-MM slave that fills the FFT sample buffer and launches the transform
module avalon_sample_loader #(
    parameter int DATA_W = 16,
    parameter int N_SAMPLES = 256,
    parameter int ADDR_W = 10,
    parameter logic [DATA_W-1:0] START_KEY = DATA_W'(16'hFFFF),
    parameter logic [DATA_W-1:0] ABORT_KEY = DATA_W'(16'h0012),
    localparam int BA_W = $clog2(N_SAMPLES),
    localparam int CNT_W = $clog2(N_SAMPLES + 1)
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              slave_chipselect,
    input  logic              slave_read,
    input  logic              slave_write,
    input  logic [ADDR_W-1:0] slave_address,
    input  logic [DATA_W-1:0] slave_writedata,
    output logic [DATA_W-1:0] slave_readdata,
    output logic              buf_wen,
    output logic [BA_W-1:0]   buf_waddr,
    output logic [DATA_W-1:0] buf_wdata,
    output logic              fft_start,
    input  logic              fft_done
);
    localparam int CW = CNT_W < DATA_W - 3 ? CNT_W : DATA_W - 3;
    localparam logic [ADDR_W-1:0] CTRL_ADDR = ADDR_W'(N_SAMPLES);
    localparam logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(N_SAMPLES + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(N_SAMPLES);

    typedef enum logic [1:0] {IDLE, LOAD, START, BUSY} state_t;

    state_t            state;
    logic [CNT_W-1:0]  count;
    logic              drop;
    logic [DATA_W-1:0] status;
    logic              wr, rd, sample_hit, arm, abort;

    assign wr = slave_chipselect & slave_write;
    assign rd = slave_chipselect & slave_read & ~slave_write;
    assign sample_hit = wr && slave_address < CTRL_ADDR;
    assign arm = wr && slave_address == CTRL_ADDR && slave_writedata == START_KEY;
    assign abort = wr && slave_address == CTRL_ADDR && slave_writedata == ABORT_KEY;

    // status word: armed, busy, drop sticky and sample count
    always_comb begin
        status = '0;
        status[0] = state == LOAD;
        status[1] = state == START || state == BUSY;
        status[2] = drop;
        status[3 +: CW] = count[CW-1:0];
    end

    // load FSM with registered bus, buffer and start outputs; abort overrides everything
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
            count <= '0;
            drop <= 1'b0;
            slave_readdata <= '0;
            buf_wen <= 1'b0;
            buf_waddr <= '0;
            buf_wdata <= '0;
            fft_start <= 1'b0;
        end else begin
            buf_wen <= 1'b0;
            fft_start <= 1'b0;
            slave_readdata <= rd && slave_address == STATUS_ADDR ? status : '0;
            if (abort) begin
                state <= IDLE;
                count <= '0;
            end else begin
                if (sample_hit) begin
                    if (state == LOAD && count != FULL) begin
                        buf_wen <= 1'b1;
                        buf_waddr <= slave_address[BA_W-1:0];
                        buf_wdata <= slave_writedata;
                        count <= count + 1'b1;
                    end else begin
                        drop <= 1'b1;
                    end
                end
                case (state)
                    IDLE: if (arm) begin
                        state <= LOAD;
                        count <= '0;
                        drop <= 1'b0;
                    end
                    LOAD: if (count == FULL) begin
                        state <= START;
                        fft_start <= 1'b1;
                    end
                    START: begin
                        state <= BUSY;
                        count <= '0;
                    end
                    default: if (fft_done) state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_avalon_sample_loader.sv
// tb_avalon_sample_loader: random and directed checks of two loader instances against a block-level model
module tb_avalon_sample_loader;
    logic clk = 1'b0;
    logic n_rst = 1'b1;
    logic cs = 1'b0, rd = 1'b0, wr = 1'b0, done = 1'b0;
    logic [9:0] addr = '0;
    logic [15:0] wdata = '0;
    logic [15:0] rdata0, wdat0;
    logic [7:0] waddr0;
    logic wen0, start0;
    logic [11:0] rdata1, wdat1;
    logic [2:0] waddr1;
    logic wen1, start1;
    int nvec = 0, nerr = 0, starts0 = 0;

    int n[2] = '{256, 8};
    int amask[2] = '{1023, 15};
    int dmask[2] = '{'hFFFF, 'hFFF};
    int skey[2] = '{'hFFFF, 'hFFF};
    bit arm_m[2], run_m[2], go_m[2], drp_m[2];
    int cnt_m[2], e_rd[2], e_wen[2], e_wa[2], e_wd[2];

    always #5 clk = ~clk;

    avalon_sample_loader u0 (
        .clk(clk), .n_rst(n_rst), .slave_chipselect(cs), .slave_read(rd), .slave_write(wr),
        .slave_address(addr), .slave_writedata(wdata), .slave_readdata(rdata0),
        .buf_wen(wen0), .buf_waddr(waddr0), .buf_wdata(wdat0), .fft_start(start0), .fft_done(done)
    );

    avalon_sample_loader #(.DATA_W(12), .N_SAMPLES(8), .ADDR_W(4)) u1 (
        .clk(clk), .n_rst(n_rst), .slave_chipselect(cs), .slave_read(rd), .slave_write(wr),
        .slave_address(addr[3:0]), .slave_writedata(wdata[11:0]), .slave_readdata(rdata1),
        .buf_wen(wen1), .buf_waddr(waddr1), .buf_wdata(wdat1), .fft_start(start1), .fft_done(done)
    );

    always @(negedge clk) if (start0) starts0++;

    task automatic chk(input string tag, input int got, input int exp);
        nvec++;
        if (got != exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // block-level model: one bus cycle seen by instance i
    task automatic model(input int i, input bit w, input bit r, input int a0, input int d0, input bit dn);
        int a = a0 & amask[i];
        int d = d0 & dmask[i];
        bit ctl = w && a == n[i];
        bit pa = arm_m[i], pr = run_m[i], pg = go_m[i];
        int pc = cnt_m[i];
        e_rd[i] = (r && !w && a == n[i] + 1) ? arm_m[i] + 2 * run_m[i] + 4 * drp_m[i] + 8 * cnt_m[i] : 0;
        e_wen[i] = 0;
        if (ctl && d == 'h12) begin
            arm_m[i] = 0; run_m[i] = 0; go_m[i] = 0; cnt_m[i] = 0;
            return;
        end
        if (w && a < n[i]) begin
            if (pa && pc < n[i]) begin
                e_wen[i] = 1; e_wa[i] = a; e_wd[i] = d; cnt_m[i] = pc + 1;
            end else drp_m[i] = 1;
        end
        if (pa && pc == n[i]) begin arm_m[i] = 0; run_m[i] = 1; go_m[i] = 1; end
        if (pg) begin go_m[i] = 0; cnt_m[i] = 0; end
        if (pr && !pg && dn) run_m[i] = 0;
        if (!pa && !pr && ctl && d == skey[i]) begin arm_m[i] = 1; cnt_m[i] = 0; drp_m[i] = 0; end
    endtask

    task automatic step(input bit c, input bit w, input bit r, input int a, input int d, input bit dn);
        cs = c; wr = w; rd = r; addr = a[9:0]; wdata = d[15:0]; done = dn;
        @(posedge clk);
        for (int i = 0; i < 2; i++) model(i, c && w, c && r, a, d, dn);
        #1;
        chk("rdata0", rdata0, e_rd[0]);
        chk("wen0", wen0, e_wen[0]);
        if (e_wen[0] != 0) begin chk("waddr0", waddr0, e_wa[0]); chk("wdata0", wdat0, e_wd[0]); end
        chk("start0", start0, go_m[0]);
        chk("rdata1", rdata1, e_rd[1]);
        chk("wen1", wen1, e_wen[1]);
        if (e_wen[1] != 0) begin chk("waddr1", waddr1, e_wa[1]); chk("wdata1", wdat1, e_wd[1]); end
        chk("start1", start1, go_m[1]);
        cs = 0; wr = 0; rd = 0; done = 0;
    endtask

    task automatic wr_(input int a, input int d); step(1, 1, 0, a, d, 0); endtask
    task automatic rd_(input int a); step(1, 0, 1, a, 0, 0); endtask
    task automatic idle(); step(0, 0, 0, 0, 0, 0); endtask

    task automatic do_reset();
        n_rst = 0;
        #2;
        chk("rst_rdata0", rdata0, 0); chk("rst_wen0", wen0, 0); chk("rst_waddr0", waddr0, 0);
        chk("rst_wdata0", wdat0, 0); chk("rst_start0", start0, 0);
        chk("rst_rdata1", rdata1, 0); chk("rst_wen1", wen1, 0); chk("rst_start1", start1, 0);
        for (int i = 0; i < 2; i++) begin
            arm_m[i] = 0; run_m[i] = 0; go_m[i] = 0; drp_m[i] = 0; cnt_m[i] = 0; e_wen[i] = 0;
        end
        @(posedge clk);
        #1;
        n_rst = 1;
    endtask

    initial begin
        int a, d;
        #1;
        do_reset();
        rd_(257);
        chk("reset_status", rdata0, 0);
        wr_(256, 'hFFFF);
        for (int k = 0; k < 256; k++) wr_(k, k);
        chk("last_wen", wen0, 1);
        idle();
        chk("start_at_t2", start0, 1);
        idle();
        chk("start_single", start0, 0);
        rd_(257);
        chk("busy_status", rdata0, 'h2);
        wr_(5, 'hABCD);
        chk("busy_no_wen", wen0, 0);
        rd_(257);
        chk("busy_drop", rdata0, 'h6);
        step(0, 0, 0, 0, 0, 1);
        rd_(257);
        chk("done_status", rdata0, 'h4);
        wr_(256, 'hFFFF);
        rd_(257);
        chk("rearm_status", rdata0, 'h1);
        for (int k = 0; k < 100; k++) wr_($urandom_range(0, 255), $urandom_range(0, 'hFFFF));
        rd_(257);
        chk("count100", rdata0, 'h321);
        wr_(256, 'h12);
        rd_(257);
        chk("abort_status", rdata0, 0);
        repeat (3) idle();
        chk("starts_after_abort", starts0, 1);
        wr_(256, 'hFFFF);
        for (int k = 0; k < 255; k++) wr_(k, 'h5A00 + k);
        wr_(255, 'h1234);
        chk("wen_256th", wen0, 1);
        wr_(256, 'h12);
        repeat (3) idle();
        chk("abort_suppress", starts0, 1);
        rd_(257);
        chk("abort_idle", rdata0, 0);
        do_reset();
        wr_(8, 'hFFF);
        for (int k = 0; k < 8; k++) wr_(k, 'hA0 + k);
        idle();
        chk("small_start", start1, 1);
        idle();
        rd_(9);
        chk("small_busy", rdata1, 'h2);
        step(0, 0, 0, 0, 0, 1);
        wr_(8, 'hFFF);
        for (int k = 0; k < 3; k++) wr_(k, k);
        do_reset();
        rd_(9);
        chk("small_reset_status", rdata1, 0);
        for (int k = 0; k < 3000; k++) begin
            case ($urandom_range(0, 9))
                0: a = 256;
                1: a = 257;
                2: a = 8;
                3: a = 9;
                4: a = $urandom_range(0, 1023);
                default: a = $urandom_range(0, 255);
            endcase
            case ($urandom_range(0, 11))
                0: d = 'hFFFF;
                1: d = 'hFFF;
                2: d = ($urandom_range(0, 3) == 0) ? 'h12 : 'h13;
                default: d = $urandom_range(0, 'hFFFF);
            endcase
            step($urandom_range(0, 7) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0, a, d,
                 $urandom_range(0, 7) == 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
